// File: rtl/dmem_arbiter.sv
// Arbiter between the arm core (port C) and a debug/DMA loader (port D) for the
// single-port dmem; port D wins on core idle or bounded starvation, then bursts.
module dmem_arbiter #(
    parameter int MAXWAIT = 4,
    parameter int LENW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            c_req,
    input  logic            c_we,
    input  logic [31:0]     c_addr,
    input  logic [31:0]     c_wdata,
    output logic [31:0]     c_rdata,
    output logic            c_stall,
    output logic            c_gnt,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [31:0]     d_addr,
    input  logic [LENW-1:0] d_len,
    input  logic [31:0]     d_wdata,
    output logic            d_gnt,
    output logic            d_beat,
    output logic            d_rvalid,
    output logic [31:0]     d_rdata,
    output logic            m_we,
    output logic [31:0]     m_addr,
    output logic [31:0]     m_wdata,
    input  logic [31:0]     m_rdata
);

    localparam int            WW       = $clog2(MAXWAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAXWAIT);

    typedef enum logic {IDLE, BURST} state_e;

    state_e          state_q, state_d;
    logic [31:0]     burst_addr_q, burst_addr_d;
    logic [LENW-1:0] beats_left_q, beats_left_d;
    logic            burst_we_q, burst_we_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            d_win;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path can infer a latch.
        state_d      = state_q;
        burst_addr_d = burst_addr_q;
        beats_left_d = beats_left_q;
        burst_we_d   = burst_we_q;
        wait_cnt_d   = wait_cnt_q;
        c_gnt        = 1'b0;
        d_gnt        = 1'b0;
        d_beat       = 1'b0;
        d_win        = 1'b0;
        m_we         = 1'b0;
        m_addr       = c_addr;
        m_wdata      = c_wdata;

        case (state_q)
            IDLE: begin
                d_win = d_req & (~c_req | (wait_cnt_q == WAIT_MAX));
                if (d_win) begin
                    d_gnt        = 1'b1;
                    d_beat       = 1'b1;
                    m_we         = d_we;
                    m_addr       = d_addr;
                    m_wdata      = d_wdata;
                    burst_addr_d = d_addr + 32'd4;
                    beats_left_d = d_len;
                    burst_we_d   = d_we;
                    wait_cnt_d   = '0;
                    state_d      = (d_len != '0) ? BURST : IDLE;
                end else if (c_req) begin
                    c_gnt = 1'b1;
                    m_we  = c_we;
                    // Starvation counter saturates so port D's win condition stays true.
                    if (d_req && wait_cnt_q != WAIT_MAX)
                        wait_cnt_d = wait_cnt_q + WW'(1);
                end
                if (!d_req)
                    wait_cnt_d = '0;
            end
            BURST: begin
                // The burst runs to completion from latched fields; d_req is ignored here.
                d_beat       = 1'b1;
                m_we         = burst_we_q;
                m_addr       = burst_addr_q;
                m_wdata      = d_wdata;
                burst_addr_d = burst_addr_q + 32'd4;
                beats_left_d = beats_left_q - LENW'(1);
                if (beats_left_q == LENW'(1))
                    state_d = IDLE;
            end
        endcase

        d_rvalid_d = d_beat & ~m_we;
        d_rdata_d  = d_rvalid_d ? m_rdata : d_rdata_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            burst_addr_q <= '0;
            beats_left_q <= '0;
            burst_we_q   <= 1'b0;
            wait_cnt_q   <= '0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            burst_addr_q <= burst_addr_d;
            beats_left_q <= beats_left_d;
            burst_we_q   <= burst_we_d;
            wait_cnt_q   <= wait_cnt_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign c_stall  = c_req & ~c_gnt;
    assign c_rdata  = m_rdata;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and burst sequencer for the single-port data memory (`dmem`). It sits between `dmem` and two requesters: the `arm` core on port C, and a debug/DMA loader on port D. The core gets zero-latency combinational access by default. Port D wins the memory either when the core is idle or after a bounded starvation wait, then owns it for an incrementing multi-word burst. While the core is denied, the block drives a stall to it.

## Interface
Parameters:
- `MAXWAIT`, default 4: consecutive contended cycles port D may be denied before it must win (1..15).
- `LENW`, default 4: width of the burst-length field.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `c_req`  in  1  core requests a memory access this cycle.
- `c_we`  in  1  core access is a write.
- `c_addr`  in  32  core byte address, word aligned.
- `c_wdata`  in  32  core write data.
- `c_rdata`  out  32  core read data, equal to `m_rdata`.
- `c_stall`  out  1  `c_req & ~c_gnt`; the core holds PC and suppresses its register write.
- `c_gnt`  out  1  core access is performed this cycle.
- `d_req`  in  1  port D requests a burst.
- `d_we`  in  1  the burst is a write burst; sampled at grant.
- `d_addr`  in  32  burst start byte address, word aligned; sampled at grant.
- `d_len`  in  LENW  beats minus 1; sampled at grant.
- `d_wdata`  in  32  write data for the current beat; must be valid whenever `d_beat` = 1.
- `d_gnt`  out  1  one-cycle pulse marking burst acceptance; this is also the first beat.
- `d_beat`  out  1  a port D beat is performed on memory this cycle.
- `d_rvalid`  out  1  registered read data is valid.
- `d_rdata`  out  32  registered read data.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  32  memory address.
- `m_wdata`  out  32  memory write data.
- `m_rdata`  in  32  memory combinational read data.

## Operation
States:
- `IDLE`: the core owns memory by default.
- `BURST`: port D owns memory.

Registers:
- `burst_addr` (32)
- `beats_left` (LENW)
- `burst_we`
- `wait_cnt` (width to hold MAXWAIT)
- `d_rvalid`, `d_rdata`

Arbitration in IDLE:
- Port D wins when `d_req & (~c_req | wait_cnt == MAXWAIT)`.
- On a port D win:
  - `d_gnt` = `d_beat` = 1; memory is driven with `d_addr`, `d_we`, `d_wdata`.
  - Latch `burst_addr` ← `d_addr + 4`, `beats_left` ← `d_len`, `burst_we` ← `d_we`; clear `wait_cnt`.
  - Next state is BURST if `d_len != 0`, otherwise IDLE.
- Otherwise, if `c_req`:
  - `c_gnt` = 1; memory is driven with `c_addr`, `c_we & c_req`, `c_wdata`.
  - If `d_req` is also high, `wait_cnt` increments, saturating at MAXWAIT.
- If `d_req` = 0, `wait_cnt` ← 0.
- With no request, `m_we` = 0 and `m_addr` = `c_addr`.

BURST:
- Each cycle: `d_beat` = 1; memory is driven with `burst_addr`, `burst_we`, `d_wdata`.
- `burst_addr` += 4, wrapping modulo 2^32; `beats_left` −= 1.
- When `beats_left` == 1, return to IDLE after this beat.
- `c_gnt` = 0, so `c_stall` = `c_req`.
- `d_req` and the `d_*` request fields are ignored; dropping `d_req` mid-burst does not abort the burst.

Read data:
- Every read beat sets `d_rvalid` = 1 on the next cycle, with `d_rdata` = `m_rdata` captured at that beat.
- Otherwise `d_rvalid` = 0.

Address width:
- Addresses pass through unmodified; no alignment correction is applied.

## Timing
- Reset values:
  - state IDLE; `burst_addr`, `beats_left`, `burst_we`, `wait_cnt`, `d_rvalid`, `d_rdata` all 0.
  - Combinational outputs with no request: `m_we` = 0, `c_gnt` = 0, `d_gnt` = 0, `d_beat` = 0, `c_stall` = 0.
- Core access latency is 0: grant, write and read all complete in the request cycle, matching the single-cycle core.
- A port D burst occupies `d_len+1` consecutive cycles starting at the grant cycle. Read data follows each beat by 1 cycle.
- Worst-case core stall is `2^LENW` cycles per port D win.
- Worst-case port D wait under continuous core traffic is MAXWAIT denied cycles; it wins on cycle MAXWAIT+1.
- Simultaneous `c_req` and `d_req` with `wait_cnt` < MAXWAIT: the core wins.
- `reset` mid-burst: the state machine and all registers clear immediately (asynchronous). No further beats occur; no `d_rvalid` is produced for in-flight beats.

## Test plan
1. Reset asserted then released, no requests → `m_we` = 0, `c_stall` = 0, `d_rvalid` = 0, `d_gnt` = 0 every cycle.
2. Core-only write with `c_addr` = 100, `c_wdata` = 7 → same cycle: `c_gnt` = 1, `m_we` = 1, `m_addr` = 100, `m_wdata` = 7, `c_stall` = 0.
3. Core idle; port D read with `d_addr` = 0x40, `d_len` = 3; memory preloaded with A, B, C, D at those words →
   - `m_addr` = 0x40, 0x44, 0x48, 0x4C on 4 consecutive cycles.
   - `d_gnt` high on the first cycle only.
   - `d_rvalid` high on cycles 2–5 with data A, B, C, D.
4. `c_req` held high; `d_req` with `d_len` = 0, MAXWAIT = 4 → port D denied 4 cycles, granted on cycle 5; `c_stall` high exactly on that cycle; `wait_cnt` returns to 0.
5. `c_req` held high; port D write burst at 0x60, `d_len` = 2, data 1, 2, 3 → memory words 0x60/0x64/0x68 = 1/2/3; `c_stall` high for 3 cycles; core resumes on the next cycle.
6. `reset` pulsed on the 2nd beat of a `d_len` = 5 read burst → from that point `d_beat` = 0, `m_we` = 0, `d_rvalid` = 0; after release the core is granted immediately.
